// File: rtl/axi_rr_wr_scheduler_pkg.sv
// Shared definitions for the AXI round-robin write scheduler.
// Holds the scheduler FSM state encoding and the width of the
// outstanding-write counter so the top level and any checkers agree.
package axi_rr_wr_scheduler_pkg;

  // Width of the outstanding-write counter (covers MAX_OUTSTANDING up to 255).
  localparam int OUTSTANDING_W = 8;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi_rr_wr_scheduler_rr_pick.sv
// Round-robin priority picker.
// Scans the request vector starting one past last_ptr and wrapping modulo N,
// returning the first requesting index.
// Ports:
//   req      - request vector, one bit per master
//   last_ptr - index of the most recently served master
//   idx      - chosen master index (don't-care when req == 0)
module rr_pick #(
  parameter int M_WIDTH = 2
) (
  input  logic [(1<<M_WIDTH)-1:0] req,
  input  logic [M_WIDTH-1:0]      last_ptr,
  output logic [M_WIDTH-1:0]      idx
);

  localparam int N = 1 << M_WIDTH;

  logic                found;
  logic [M_WIDTH-1:0]  cand;

  // Offsets 1..N; the M_WIDTH-bit add wraps naturally, and offset N lands
  // back on last_ptr itself so a lone repeat requester still wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = last_ptr + M_WIDTH'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rr_wr_scheduler.sv
// AXI write-channel round-robin scheduler.
// Arbitrates AW requests from N = 2**M_WIDTH masters, gates the muxed AW and
// W channels toward the bus for the granted master, and tracks accepted
// writes still awaiting a B response, throttling new grants at
// MAX_OUTSTANDING.
// Ports:
//   clk, rstn                 - clock, asynchronous active-low reset
//   m_wr_addr_valid           - per-master AW valid (request vector)
//   bus_wr_addr_ready         - downstream AW ready
//   bus_wr_data_valid/ready/last - muxed W handshake and last beat
//   bus_wr_back_valid/ready   - B handshake
//   wr_addr_master_sel/wr_data_master_sel - mux selects (hold grant)
//   wr_addr_gate/wr_data_gate - qualify muxed AW / W valid toward the bus
//   outstanding               - accepted writes awaiting B
//   resp_underflow_err        - sticky: B handshake seen with outstanding == 0
//   fsm_state                 - scheduler state for observation
//
// Handshake semantics: a transfer on any channel happens on a rising edge
// where both valid and ready are 1. An AW transfer counts only while in ADDR
// (wr_addr_gate = 1); a W transfer only while in DATA (wr_data_gate = 1).
// B transfers are counted in every state.
module axi_rr_wr_scheduler
  import axi_rr_wr_scheduler_pkg::*;
#(
  parameter int M_WIDTH         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [(1<<M_WIDTH)-1:0]    m_wr_addr_valid,
  input  logic                       bus_wr_addr_ready,
  input  logic                       bus_wr_data_valid,
  input  logic                       bus_wr_data_ready,
  input  logic                       bus_wr_data_last,
  input  logic                       bus_wr_back_valid,
  input  logic                       bus_wr_back_ready,
  output logic [M_WIDTH-1:0]         wr_addr_master_sel,
  output logic [M_WIDTH-1:0]         wr_data_master_sel,
  output logic                       wr_addr_gate,
  output logic                       wr_data_gate,
  output logic [OUTSTANDING_W-1:0]   outstanding,
  output logic                       resp_underflow_err,
  output logic [1:0]                 fsm_state
);

  wr_state_e                  state_q, state_d;
  logic [M_WIDTH-1:0]         grant_q, grant_d;
  logic [M_WIDTH-1:0]         last_ptr_q, last_ptr_d;
  logic [OUTSTANDING_W-1:0]   out_q, out_d;
  logic                       err_q, err_d;
  logic [M_WIDTH-1:0]         pick_idx;

  logic aw_hs;
  logic w_last_hs;
  logic b_hs;
  logic can_issue;

  rr_pick #(
    .M_WIDTH (M_WIDTH)
  ) u_rr_pick (
    .req      (m_wr_addr_valid),
    .last_ptr (last_ptr_q),
    .idx      (pick_idx)
  );

  assign aw_hs     = (state_q == ADDR) && bus_wr_addr_ready;
  assign w_last_hs = (state_q == DATA) && bus_wr_data_valid &&
                     bus_wr_data_ready && bus_wr_data_last;
  assign b_hs      = bus_wr_back_valid && bus_wr_back_ready;
  assign can_issue = out_q < OUTSTANDING_W'(MAX_OUTSTANDING);

  // Next state, grant capture and round-robin pointer update.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    case (state_q)
      IDLE: begin
        if ((|m_wr_addr_valid) && can_issue) begin
          state_d = ADDR;
          grant_d = pick_idx;
        end
      end
      ADDR: begin
        // Grant is held here regardless of the master's valid.
        if (bus_wr_addr_ready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        // Priority rotates only once the whole burst has gone through.
        if (w_last_hs) begin
          state_d    = IDLE;
          last_ptr_d = grant_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outstanding counter and sticky underflow flag.
  always_comb begin
    out_d = out_q;
    err_d = err_q;
    if (b_hs && (out_q == '0)) begin
      err_d = 1'b1;
    end
    case ({aw_hs, b_hs})
      2'b10:   out_d = out_q + OUTSTANDING_W'(1);
      2'b01:   out_d = (out_q == '0) ? out_q : out_q - OUTSTANDING_W'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_ptr_q <= '1;
      out_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
      out_q      <= out_d;
      err_q      <= err_d;
    end
  end

  // Gates decode straight from the state register so reset drops them
  // without waiting for a clock edge.
  assign wr_addr_gate       = (state_q == ADDR);
  assign wr_data_gate       = (state_q == DATA);
  assign wr_addr_master_sel = grant_q;
  assign wr_data_master_sel = grant_q;
  assign outstanding        = out_q;
  assign resp_underflow_err = err_q;
  assign fsm_state          = state_q;

endmodule

// File: tb/tb_axi_rr_wr_scheduler.sv
module tb_axi_rr_wr_scheduler;
  import axi_rr_wr_scheduler_pkg::*;

  logic       clk;
  logic       rstn;
  logic [3:0] m_wr_addr_valid;
  logic       bus_wr_addr_ready;
  logic       bus_wr_data_valid;
  logic       bus_wr_data_ready;
  logic       bus_wr_data_last;
  logic       bus_wr_back_valid;
  logic       bus_wr_back_ready;
  logic [1:0] wr_addr_master_sel;
  logic [1:0] wr_data_master_sel;
  logic       wr_addr_gate;
  logic       wr_data_gate;
  logic [7:0] outstanding;
  logic       resp_underflow_err;
  logic [1:0] fsm_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int         model_last;
  int         model_out;
  logic       model_err;
  logic [1:0] cur_grant;
  logic [1:0] exp_q[$];

  axi_rr_wr_scheduler #(
    .M_WIDTH         (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .m_wr_addr_valid    (m_wr_addr_valid),
    .bus_wr_addr_ready  (bus_wr_addr_ready),
    .bus_wr_data_valid  (bus_wr_data_valid),
    .bus_wr_data_ready  (bus_wr_data_ready),
    .bus_wr_data_last   (bus_wr_data_last),
    .bus_wr_back_valid  (bus_wr_back_valid),
    .bus_wr_back_ready  (bus_wr_back_ready),
    .wr_addr_master_sel (wr_addr_master_sel),
    .wr_data_master_sel (wr_data_master_sel),
    .wr_addr_gate       (wr_addr_gate),
    .wr_data_gate       (wr_data_gate),
    .outstanding        (outstanding),
    .resp_underflow_err (resp_underflow_err),
    .fsm_state          (fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] rr_model(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return 2'((last + k) % 4);
    end
    return 2'd0;
  endfunction

  // Driver tasks -- all return at posedge + 1.
  task automatic apply_reset();
    rstn = 1'b0;
    m_wr_addr_valid = '0;
    bus_wr_addr_ready = 1'b0;
    bus_wr_data_valid = 1'b0;
    bus_wr_data_ready = 1'b0;
    bus_wr_data_last = 1'b0;
    bus_wr_back_valid = 1'b0;
    bus_wr_back_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({wr_addr_gate, wr_data_gate} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_gates: got %b expected 00", {wr_addr_gate, wr_data_gate});
    end
    tests_run++;
    if ({wr_addr_master_sel, wr_data_master_sel} !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_sels: got %h expected 0", {wr_addr_master_sel, wr_data_master_sel});
    end
    tests_run++;
    if (outstanding !== 8'd0 || resp_underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_count_err: got %0d/%b expected 0/0", outstanding, resp_underflow_err);
    end
    tests_run++;
    if (fsm_state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected %0d", fsm_state, IDLE);
    end
    rstn = 1'b1;
    model_last = 3;
    model_out  = 0;
    model_err  = 1'b0;
    exp_q.delete();
  endtask

  // Requests, waits (bounded) for the AW gate, checks the grant, then
  // performs the AW handshake, optionally together with a B handshake.
  task automatic start_write(input logic [3:0] req, input bit with_b);
    int n;
    logic [1:0] exp;
    m_wr_addr_valid = req;
    exp_q.push_back(rr_model(req, model_last));
    n = 0;
    while (wr_addr_gate !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (wr_addr_gate !== 1'b1) begin
      tests_failed++;
      $display("FAIL aw_gate_timeout: got %b expected 1 within 20 cycles", wr_addr_gate);
    end
    exp = exp_q.pop_front();
    cur_grant = exp;
    tests_run++;
    if (wr_addr_master_sel !== exp) begin
      tests_failed++;
      $display("FAIL aw_grant: got %0d expected %0d", wr_addr_master_sel, exp);
    end
    bus_wr_addr_ready = 1'b1;
    bus_wr_back_valid = with_b;
    bus_wr_back_ready = with_b;
    @(posedge clk); #1;
    bus_wr_addr_ready = 1'b0;
    bus_wr_back_valid = 1'b0;
    bus_wr_back_ready = 1'b0;
    if (!with_b) model_out++;
    tests_run++;
    if ({wr_addr_gate, wr_data_gate} !== 2'b01 || wr_data_master_sel !== exp) begin
      tests_failed++;
      $display("FAIL data_phase: got gates %b sel %0d expected 01 sel %0d",
               {wr_addr_gate, wr_data_gate}, wr_data_master_sel, exp);
    end
    tests_run++;
    if (outstanding !== 8'(model_out)) begin
      tests_failed++;
      $display("FAIL outstanding_after_aw: got %0d expected %0d", outstanding, model_out);
    end
  endtask

  // Drives n W beats; if abort_at matches a beat index, drops rstn
  // mid-cycle during that beat and checks the asynchronous response.
  task automatic send_beats(input int n, input int abort_at);
    for (int b = 0; b < n; b++) begin
      bus_wr_data_valid = 1'b1;
      bus_wr_data_ready = 1'b1;
      bus_wr_data_last  = (b == n - 1);
      if (b == abort_at) begin
        #2;
        rstn = 1'b0;
        #1;
        tests_run++;
        if ({wr_addr_gate, wr_data_gate} !== 2'b00) begin
          tests_failed++;
          $display("FAIL async_reset_gates: got %b expected 00", {wr_addr_gate, wr_data_gate});
        end
        tests_run++;
        if (outstanding !== 8'd0 || wr_data_master_sel !== 2'd0 || fsm_state !== IDLE) begin
          tests_failed++;
          $display("FAIL async_reset_state: got out %0d sel %0d state %0d expected 0 0 0",
                   outstanding, wr_data_master_sel, fsm_state);
        end
        return;
      end
      @(posedge clk); #1;
      if (b != n - 1) begin
        tests_run++;
        if (wr_data_gate !== 1'b1) begin
          tests_failed++;
          $display("FAIL beat_no_last: got data gate %b expected 1", wr_data_gate);
        end
      end
    end
    bus_wr_data_valid = 1'b0;
    bus_wr_data_ready = 1'b0;
    bus_wr_data_last  = 1'b0;
    model_last = int'(cur_grant);
    tests_run++;
    if (fsm_state !== IDLE || wr_data_gate !== 1'b0 || wr_addr_master_sel !== cur_grant) begin
      tests_failed++;
      $display("FAIL burst_end: got state %0d gate %b sel %0d expected %0d 0 %0d",
               fsm_state, wr_data_gate, wr_addr_master_sel, IDLE, cur_grant);
    end
  endtask

  task automatic send_b();
    bus_wr_back_valid = 1'b1;
    bus_wr_back_ready = 1'b1;
    @(posedge clk); #1;
    bus_wr_back_valid = 1'b0;
    bus_wr_back_ready = 1'b0;
    if (model_out == 0) model_err = 1'b1;
    else model_out--;
    tests_run++;
    if (outstanding !== 8'(model_out) || resp_underflow_err !== model_err) begin
      tests_failed++;
      $display("FAIL b_handshake: got %0d/%b expected %0d/%b",
               outstanding, resp_underflow_err, model_out, model_err);
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    apply_reset();
    m_wr_addr_valid = 4'b1010;
    @(posedge clk); #1;
    tests_run++;
    if (wr_addr_gate !== 1'b1 || wr_addr_master_sel !== 2'd1) begin
      tests_failed++;
      $display("FAIL first_grant_latency: got gate %b sel %0d expected 1 1",
               wr_addr_gate, wr_addr_master_sel);
    end
    start_write(4'b1010, 1'b0);
    send_beats(2, -1);
  endtask

  task automatic test_fairness();
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      start_write(4'b1111, 1'b0);
      tests_run++;
      if (cur_grant !== order[i]) begin
        tests_failed++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", i, cur_grant, order[i]);
      end
      send_beats(1, -1);
      send_b();
    end
    m_wr_addr_valid = '0;
  endtask

  task automatic test_outstanding_limit();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      start_write(4'b0001, 1'b0);
      send_beats(1 + $urandom_range(0, 3), -1);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (outstanding !== 8'd2 || fsm_state !== IDLE || wr_addr_gate !== 1'b0) begin
      tests_failed++;
      $display("FAIL limit_hold: got out %0d state %0d gate %b expected 2 %0d 0",
               outstanding, fsm_state, wr_addr_gate, IDLE);
    end
    send_b();
    @(posedge clk); #1;
    tests_run++;
    if (wr_addr_gate !== 1'b1) begin
      tests_failed++;
      $display("FAIL limit_release: got gate %b expected 1", wr_addr_gate);
    end
    start_write(4'b0001, 1'b0);
    send_beats(1, -1);
    m_wr_addr_valid = '0;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    start_write(4'b0001, 1'b0);
    send_beats(1, -1);
    // outstanding is 1; AW and B land on the same edge.
    start_write(4'b0010, 1'b1);
    send_beats(1, -1);
    m_wr_addr_valid = '0;
  endtask

  task automatic test_underflow();
    apply_reset();
    // W activity outside DATA must not move the FSM.
    bus_wr_data_valid = 1'b1;
    bus_wr_data_ready = 1'b1;
    bus_wr_data_last  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus_wr_data_valid = 1'b0;
    bus_wr_data_ready = 1'b0;
    bus_wr_data_last  = 1'b0;
    tests_run++;
    if (fsm_state !== IDLE || wr_data_gate !== 1'b0) begin
      tests_failed++;
      $display("FAIL w_outside_data: got state %0d expected %0d", fsm_state, IDLE);
    end
    send_b();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (resp_underflow_err !== 1'b1 || outstanding !== 8'd0) begin
      tests_failed++;
      $display("FAIL underflow_sticky: got %b/%0d expected 1/0", resp_underflow_err, outstanding);
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    start_write(4'b0100, 1'b0);
    send_beats(8, 2);
    @(posedge clk); #1;
    bus_wr_data_valid = 1'b0;
    bus_wr_data_ready = 1'b0;
    bus_wr_data_last  = 1'b0;
    m_wr_addr_valid   = '0;
    rstn = 1'b1;
    model_last = 3;
    model_out  = 0;
    model_err  = 1'b0;
    exp_q.delete();
    start_write(4'b1111, 1'b0);
    tests_run++;
    if (cur_grant !== 2'd0 || resp_underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_winner: got %0d err %b expected 0 err 0",
               wr_addr_master_sel, resp_underflow_err);
    end
    send_beats(1, -1);
    m_wr_addr_valid = '0;
  endtask

  initial begin
    rstn = 1'b0;
    test_reset();
    test_fairness();
    test_outstanding_limit();
    test_simultaneous();
    test_underflow();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
